// File: rtl/reg_ram_arbiter.sv
// reg_ram_arbiter: round-robin two-requester front end for a single-port RAM with atomic set/clear RMW
module reg_ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          c,
    input  logic          r,
    input  logic [1:0]    req,
    input  logic [3:0]    op,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] d,
    output logic [1:0]    gnt,
    output logic [1:0]    rvld,
    output logic [DW-1:0] rq,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q
);
    typedef enum logic [1:0] {IDLE, RMW_WAIT, RMW_WR} state_t;
    state_t state;
    logic last, w, clr, rmw_w;
    logic [1:0] eff, wop, rd0, rd1;
    logic [DW-1:0] wd, mask;
    // a requester still sees its grant this cycle and has not yet updated req, so mask it out
    always_comb begin
        eff = req & ~gnt;
        w = (eff == 2'b11) ? ~last : eff[1];
        wop = w ? op[3:2] : op[1:0];
        wd = w ? d[2*DW-1:DW] : d[DW-1:0];
    end
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state <= IDLE;
            last <= 1'b1;
            gnt <= 2'b00;
            rvld <= 2'b00;
            rq <= '0;
            ram_addr <= '0;
            ram_wr <= 1'b0;
            ram_d <= '0;
            rd0 <= 2'b00;
            rd1 <= 2'b00;
            mask <= '0;
            clr <= 1'b0;
            rmw_w <= 1'b0;
        end else begin
            rd1 <= rd0;
            rvld <= rd1;
            if (|rd1) rq <= ram_q;
            gnt <= 2'b00;
            rd0 <= 2'b00;
            ram_wr <= 1'b0;
            case (state)
                IDLE: if (|eff) begin
                    last <= w;
                    gnt <= 2'b01 << w;
                    ram_addr <= w ? addr[2*AW-1:AW] : addr[AW-1:0];
                    ram_d <= wd;
                    ram_wr <= wop == 2'b01;
                    rd0 <= (wop == 2'b00) ? (2'b01 << w) : 2'b00;
                    if (wop[1]) begin
                        state <= RMW_WAIT;
                        mask <= wd;
                        clr <= wop[0];
                        rmw_w <= w;
                    end
                end
                RMW_WAIT: state <= RMW_WR;
                default: begin
                    rq <= ram_q;
                    rvld <= 2'b01 << rmw_w;
                    ram_wr <= 1'b1;
                    ram_d <= clr ? (ram_q & ~mask) : (ram_q | mask);
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
